mux_scan: RTL and testbench

Parametrised N-to-1 multiplexer with a registered output, the successor to the combinational 4:1 mux. It supports two modes. In manual mode the channel comes from an external select. In auto-scan mode an internal round-robin counter steps through the channels, holding each one for a programmable dwell period. It feeds serial probe and monitor logic that needs one sampled channel per cycle, tagged with its channel index.

---
 rtl/mux_scan.sv | 110 +++++++++++
 tb/tb_mux_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: N-to-1 channel multiplexer with a registered output and two ways
// of choosing the channel. In manual mode (mode=0) the external sel picks the
// channel. In auto mode (mode=1) an internal round-robin scanner steps through
// the channels and holds each one for dwell+1 enabled cycles. Every output
// sample carries the index of the channel it came from, so downstream serial
// probe/monitor logic can tag it.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, overrides all other inputs
//   in_data   N packed channels of W bits; channel k = in_data[k*W +: W]
//   en        enable; 0 freezes scan state and output data/index
//   mode      0 = manual select, 1 = auto round-robin scan
//   sel       manual channel select, used when mode=0
//   dwell     auto mode: hold each channel for dwell+1 enabled cycles
//   out_data  registered data of the selected channel
//   out_ch    channel index that out_data came from
//   out_valid out_data holds a valid sample this cycle
//   wrap      one-cycle pulse when the scan moves from channel N-1 to 0
module mux_scan #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int DW = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [DW-1:0]   dwell,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  output logic            wrap
);

  logic [SW-1:0] scan_ch_r;
  logic [DW-1:0] dwell_cnt_r;
  logic [SW-1:0] cur_ch_s;
  logic [W-1:0]  ch_data_s;
  logic          sel_in_range_s;
  logic          last_ch_s;
  logic          advance_s;

  // Choose the channel index to sample: the scanner in auto mode, sel otherwise.
  always_comb begin
    cur_ch_s = {SW{1'b0}};
    if (mode) begin
      cur_ch_s = scan_ch_r;
    end else begin
      cur_ch_s = sel;
    end
  end

  // Channel data mux. An index with no matching channel (possible only for a
  // non-power-of-two N under manual select) yields zero data.
  always_comb begin
    ch_data_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      ch_data_s = (cur_ch_s == SW'(k)) ? in_data[k*W +: W] : ch_data_s;
    end
  end

  // Scan bookkeeping: range check for sel, last-channel and dwell-expiry flags.
  always_comb begin
    sel_in_range_s = (32'(sel) < N);
    last_ch_s      = (scan_ch_r == SW'(N - 1));
    // >= rather than == so that lowering dwell mid-count advances at once.
    advance_s      = (dwell_cnt_r >= dwell);
  end

  // Output registers and round-robin scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data    <= {W{1'b0}};
      out_ch      <= {SW{1'b0}};
      out_valid   <= 1'b0;
      wrap        <= 1'b0;
      scan_ch_r   <= {SW{1'b0}};
      dwell_cnt_r <= {DW{1'b0}};
    end else if (en) begin
      // Sample uses the scan index before it advances at this edge.
      out_data  <= ch_data_s;
      out_ch    <= cur_ch_s;
      out_valid <= mode | sel_in_range_s;
      if (mode) begin
        if (advance_s) begin
          dwell_cnt_r <= {DW{1'b0}};
          scan_ch_r   <= last_ch_s ? {SW{1'b0}} : scan_ch_r + SW'(1);
          wrap        <= last_ch_s;
        end else begin
          dwell_cnt_r <= dwell_cnt_r + DW'(1);
          wrap        <= 1'b0;
        end
      end else begin
        // Held at zero so a later switch to auto starts at channel 0 with a
        // full dwell period.
        scan_ch_r   <= {SW{1'b0}};
        dwell_cnt_r <= {DW{1'b0}};
        wrap        <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Directed self-checking bench for mux_scan. A 4-channel, 4-bit instance
// covers manual select, auto scan with several dwell values, enable gaps,
// dwell changes, reset and mode changes. A 3-channel instance covers an
// out-of-range manual select.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic        mode3;
  logic [1:0]  sel;
  logic [1:0]  sel3;
  logic [7:0]  dwell;
  logic [15:0] din4;
  logic [11:0] din3;

  logic [3:0]  od4, od3;
  logic [1:0]  oc4, oc3;
  logic        ov4, ov3, wr4, wr3;

  int total = 0;
  int bad   = 0;

  logic [3:0] ch_val [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [1:0] msel   [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
  logic [3:0] mexp   [4] = '{4'hB, 4'hD, 4'hC, 4'hA};

  always #5 clk = ~clk;

  mux_scan #(.N(4), .W(4), .DW(8)) u4 (
    .clk(clk), .rst(rst), .in_data(din4), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .out_data(od4), .out_ch(oc4), .out_valid(ov4), .wrap(wr4)
  );

  mux_scan #(.N(3), .W(4), .DW(8)) u3 (
    .clk(clk), .rst(rst), .in_data(din3), .en(en), .mode(mode3), .sel(sel3),
    .dwell(dwell), .out_data(od3), .out_ch(oc3), .out_valid(ov3), .wrap(wr3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] ch, input logic [3:0] data,
                      input logic valid, input logic wr);
    chk({tag, ".ch"},    32'(oc4), 32'(ch));
    chk({tag, ".data"},  32'(od4), 32'(data));
    chk({tag, ".valid"}, 32'(ov4), 32'(valid));
    chk({tag, ".wrap"},  32'(wr4), 32'(wr));
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    mode  = 1'b0;
    mode3 = 1'b0;
    sel   = 2'd0;
    sel3  = 2'd0;
    dwell = 8'd0;
    din4  = 16'hDCBA;
    din3  = 12'h987;

    // Reset state
    tick();
    chk4("reset", 2'd0, 4'h0, 1'b0, 1'b0);
    chk("reset3.valid", 32'(ov3), 32'd0);
    rst = 1'b0;

    // Manual select, each sel held for two cycles
    for (int i = 0; i < 4; i++) begin
      sel = msel[i];
      tick();
      chk4("man_a", msel[i], mexp[i], 1'b1, 1'b0);
      tick();
      chk4("man_b", msel[i], mexp[i], 1'b1, 1'b0);
    end

    // Auto scan, dwell=0: one channel per cycle, wrap after channel 3
    mode  = 1'b1;
    dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk4("d0", 2'(i % 4), ch_val[i % 4], 1'b1, (i % 4) == 3);
    end

    // Auto scan, dwell=2: each channel held three cycles, one wrap per lap
    dwell = 8'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk4("d2", 2'(i / 3), ch_val[i / 3], 1'b1, i == 11);
    end

    // Enable gap in the middle of channel 0's dwell
    tick();
    chk4("pre_gap", 2'd0, 4'hA, 1'b1, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk4("gap", 2'd0, 4'hA, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick();
    chk4("resume0", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("resume1", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("resume2", 2'd1, 4'hB, 1'b1, 1'b0);

    // Channel data changes mid-dwell show up on the next sample
    din4 = 16'hDC5A;
    tick();
    chk4("newdata0", 2'd1, 4'h5, 1'b1, 1'b0);
    tick();
    chk4("newdata1", 2'd1, 4'h5, 1'b1, 1'b0);
    din4 = 16'hDCBA;

    // Reset again, then lower dwell from 10 to 1 while the count is at 5
    rst   = 1'b1;
    dwell = 8'd10;
    tick();
    chk4("reset2", 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk4("d10", 2'd0, 4'hA, 1'b1, 1'b0);
    end
    dwell = 8'd1;
    tick();
    chk4("lower", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("d1_a", 2'd1, 4'hB, 1'b1, 1'b0);
    tick();
    chk4("d1_b", 2'd1, 4'hB, 1'b1, 1'b0);
    tick();
    chk4("d1_c", 2'd2, 4'hC, 1'b1, 1'b0);

    // Reset while scanning channel 2, then restart from channel 0
    rst = 1'b1;
    tick();
    chk4("midrst", 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk4("restart0", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("restart1", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("restart2", 2'd1, 4'hB, 1'b1, 1'b0);

    // Auto -> manual with sel=3, then back to auto from a cleared scan
    mode = 1'b0;
    sel  = 2'd3;
    tick();
    chk4("to_man", 2'd3, 4'hD, 1'b1, 1'b0);
    mode = 1'b1;
    tick();
    chk4("to_auto0", 2'd0, 4'hA, 1'b1, 1'b0);
    tick();
    chk4("to_auto1", 2'd0, 4'hA, 1'b1, 1'b0);

    // Three-channel instance: out-of-range and in-range manual selects
    sel3 = 2'd3;
    tick();
    chk("n3_oor.valid", 32'(ov3), 32'd0);
    chk("n3_oor.data",  32'(od3), 32'h0);
    chk("n3_oor.ch",    32'(oc3), 32'd3);
    sel3 = 2'd2;
    tick();
    chk("n3_s2.valid", 32'(ov3), 32'd1);
    chk("n3_s2.data",  32'(od3), 32'h9);
    chk("n3_s2.ch",    32'(oc3), 32'd2);
    sel3 = 2'd0;
    tick();
    chk("n3_s0.data",  32'(od3), 32'h7);
    chk("n3_s0.wrap",  32'(wr3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
